// File: rtl/acf_pkg.sv
// acf_pkg: shared ACF burst sizing, receiver state encoding and error codes
package acf_pkg;
  localparam int LAGS      = 12;
  localparam int ACF_WIDTH = 43;

  typedef enum logic [2:0] {
    IDLE,
    CAPTURE,
    CHECK,
    REPLAY,
    DRAIN
  } acf_state_e;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_SHORT   = 2'b01;
  localparam logic [1:0] ERR_LONG    = 2'b10;
  localparam logic [1:0] ERR_OVERRUN = 2'b11;
endpackage

// File: rtl/acf_lag_bank.sv
// acf_lag_bank: LAGS+1 x ACF_WIDTH word store, one write port, one asynchronous read port
module acf_lag_bank #(
  parameter int LAGS      = 12,
  parameter int ACF_WIDTH = 43
) (
  input  logic                        clk_i,
  input  logic                        we_i,
  input  logic [3:0]                  waddr_i,
  input  logic signed [ACF_WIDTH-1:0] wdata_i,
  input  logic [3:0]                  raddr_i,
  output logic signed [ACF_WIDTH-1:0] rdata_o
);
  logic signed [ACF_WIDTH-1:0] mem_q [0:LAGS];

  // Contents survive reset; a discarded burst is simply overwritten by the next one.
  always_ff @(posedge clk_i)
    if (we_i) mem_q[waddr_i] <= wdata_i;

  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/acf_burst_receiver.sv
// acf_burst_receiver: captures one LAGS+1 word ACF burst, validates its length and replays it
// under ready/valid handshake. Define ACF_SILENT_SKIP_EN to drop bursts whose lag-0 word is zero.
module acf_burst_receiver
  import acf_pkg::*;
#(
  parameter int LAGS      = acf_pkg::LAGS,
  parameter int ACF_WIDTH = acf_pkg::ACF_WIDTH
) (
  input  logic                        iClock,
  input  logic                        iReset_n,
  input  logic                        iEnable,
  input  logic signed [ACF_WIDTH-1:0] iACF,
  input  logic                        iValid,
  output logic signed [ACF_WIDTH-1:0] oACF,
  output logic [3:0]                  oLag,
  output logic                        oValid,
  input  logic                        iReady,
  output logic                        oDone,
  output logic                        oError,
  output logic [1:0]                  oErrCode,
  output logic                        oSilent
);
  localparam logic [3:0] LAST = 4'(LAGS);

  acf_state_e state_q, state_d;
  logic [3:0] count_q, count_d, lag_q, lag_d;
  logic ovr_q, ovr_d;
  logic we, cap_v;
  logic [3:0] waddr;
  logic signed [ACF_WIDTH-1:0] rdata;

  assign cap_v = iEnable & iValid;

  acf_lag_bank #(.LAGS(LAGS), .ACF_WIDTH(ACF_WIDTH)) u_bank (
    .clk_i   (iClock),
    .we_i    (we),
    .waddr_i (waddr),
    .wdata_i (iACF),
    .raddr_i (lag_q),
    .rdata_o (rdata)
  );

  // The read port idles at lag 0, so CHECK sees bank[0] and REPLAY sees bank[oLag].
  assign oLag = lag_q;
  assign oACF = oValid ? rdata : '0;

  // State, write pointer, replay pointer and overrun-already-reported flag.
  always_ff @(posedge iClock or negedge iReset_n)
    if (!iReset_n) begin
      state_q <= IDLE;
      count_q <= '0;
      lag_q   <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      lag_q   <= lag_d;
      ovr_q   <= ovr_d;
    end

  // Next state and all pulse outputs; only REPLAY runs regardless of iEnable.
  always_comb begin
    state_d  = state_q;
    count_d  = '0;
    lag_d    = '0;
    ovr_d    = 1'b0;
    we       = 1'b0;
    waddr    = count_q;
    oValid   = 1'b0;
    oDone    = 1'b0;
    oError   = 1'b0;
    oErrCode = ERR_NONE;
    oSilent  = 1'b0;
    case (state_q)
      IDLE:
        if (cap_v) begin
          we      = 1'b1;
          waddr   = '0;
          count_d = 4'd1;
          state_d = CAPTURE;
        end
      CAPTURE: begin
        count_d = count_q;
        if (iEnable) begin
          if (iValid) begin
            we      = 1'b1;
            count_d = count_q + 4'd1;
            if (count_q == LAST) begin
              count_d = '0;
              state_d = CHECK;
            end
          end else begin
            oError   = 1'b1;
            oErrCode = ERR_SHORT;
            count_d  = '0;
            state_d  = IDLE;
          end
        end
      end
      CHECK:
        if (iEnable) begin
          if (iValid) begin
            oError   = 1'b1;
            oErrCode = ERR_LONG;
            state_d  = DRAIN;
          end
`ifdef ACF_SILENT_SKIP_EN
          else if (rdata == '0) begin
            oSilent = 1'b1;
            state_d = IDLE;
          end
`endif
          else state_d = REPLAY;
        end
      REPLAY: begin
        oValid = 1'b1;
        lag_d  = lag_q;
        ovr_d  = iEnable ? iValid : ovr_q;
        if (cap_v && !ovr_q) begin
          oError   = 1'b1;
          oErrCode = ERR_OVERRUN;
        end
        if (iReady) begin
          if (lag_q == LAST) begin
            oDone   = 1'b1;
            lag_d   = '0;
            state_d = cap_v ? DRAIN : IDLE;
          end else lag_d = lag_q + 4'd1;
        end
      end
      DRAIN:
        if (iEnable && !iValid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_acf_burst_receiver.sv
// tb_acf_burst_receiver: randomized scenario bench with a burst-level scoreboard for acf_burst_receiver
module tb_acf_burst_receiver;
  localparam int LAGS = 12;
  localparam int W    = 43;

  logic iClock, iReset_n, iEnable, iValid, iReady;
  logic signed [W-1:0] iACF, oACF;
  logic [3:0] oLag;
  logic oValid, oDone, oError, oSilent;
  logic [1:0] oErrCode;

  acf_burst_receiver #(.LAGS(LAGS), .ACF_WIDTH(W)) dut (
    .iClock(iClock), .iReset_n(iReset_n), .iEnable(iEnable), .iACF(iACF), .iValid(iValid),
    .oACF(oACF), .oLag(oLag), .oValid(oValid), .iReady(iReady), .oDone(oDone),
    .oError(oError), .oErrCode(oErrCode), .oSilent(oSilent)
  );

  initial iClock = 1'b0;
  always #5 iClock = ~iClock;

  int vectors = 0;
  int errs = 0;

  logic signed [W-1:0] tx[$];
  logic signed [W-1:0] got_acf[$];
  logic [3:0] got_lag[$];
  logic [1:0] err_codes[$];
  int ncyc, first_v, err_cyc, n_valid, n_done, n_baddone, n_unstable, n_silent;
  logic stalled, prev_done;
  logic signed [W-1:0] hold_acf;
  logic [3:0] hold_lag;

  function automatic logic signed [W-1:0] rnd_word();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return (W'(r) == '0) ? W'(1) : W'(r);
  endfunction

  task automatic load_tx(input int n);
    tx.delete();
    repeat (n) tx.push_back(rnd_word());
  endtask

  task automatic clear();
    got_acf.delete(); got_lag.delete(); err_codes.delete();
    ncyc = 0; first_v = -1; err_cyc = -1; n_valid = 0; n_done = 0;
    n_baddone = 0; n_unstable = 0; n_silent = 0; stalled = 0; prev_done = 0;
  endtask

  // One clock: drive at the falling edge, observe 1 time unit later, return at next falling edge.
  task automatic cyc(input logic en, input logic v, input logic signed [W-1:0] d, input logic r);
    iEnable = en; iValid = v; iACF = d; iReady = r;
    #1;
    if (prev_done && oValid) n_baddone++;
    if (oValid) begin
      if (first_v < 0) first_v = ncyc;
      if (stalled && (oACF !== hold_acf || oLag !== hold_lag)) n_unstable++;
      if (r) begin got_acf.push_back(oACF); got_lag.push_back(oLag); end
      n_valid++;
    end
    stalled = oValid && !r; hold_acf = oACF; hold_lag = oLag;
    if (oDone) begin
      n_done++;
      if (!(oValid && r && oLag == 4'(LAGS))) n_baddone++;
    end
    prev_done = oDone;
    if (oError) begin err_codes.push_back(oErrCode); if (err_cyc < 0) err_cyc = ncyc; end
    if (oSilent) n_silent++;
    @(negedge iClock);
    ncyc++;
  endtask

  // Streams tx on capture cycles, then iValid=0, for ncycles clocks.
  task automatic run(input int en_mode, input int rdy_mode, input int ncycles);
    int k;
    logic en, rdy, v;
    k = 0;
    for (int c = 0; c < ncycles; c++) begin
      en  = (en_mode == 0) ? 1'b1 : (en_mode == 1) ? (c % 2 == 0) : 1'($urandom_range(0, 1));
      rdy = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? (c % 4 == 0 || c % 4 == 3) : 1'($urandom_range(0, 1));
      v   = k < tx.size();
      cyc(en, v, v ? tx[k] : rnd_word(), rdy);
      if (en && v) k++;
    end
  endtask

  task automatic test_reset();
    iReset_n = 1'b0; iEnable = 1'b1; iValid = 1'b1; iReady = 1'b1; iACF = rnd_word();
    @(negedge iClock); @(negedge iClock);
    #1;
    vectors++;
    if ({oValid, oDone, oError, oErrCode, oSilent} !== 6'b0) begin
      errs++; $display("FAIL reset_flags: got %b required 000000", {oValid, oDone, oError, oErrCode, oSilent});
    end
    vectors++;
    if (oACF !== '0 || oLag !== 4'd0) begin
      errs++; $display("FAIL reset_data: got acf=%0d lag=%0d required 0/0", oACF, oLag);
    end
    iValid = 1'b0;
    @(negedge iClock);
    iReset_n = 1'b1;
  endtask

  task automatic test_nominal();
    tx.delete();
    for (int i = 0; i <= LAGS; i++) tx.push_back(W'(100 - 10 * i));
    clear(); run(0, 0, 40);
    vectors++;
    if (got_acf.size() != LAGS + 1 || n_valid != LAGS + 1) begin
      errs++; $display("FAIL nominal_count: got words=%0d valid=%0d required 13", got_acf.size(), n_valid);
    end
    for (int i = 0; i <= LAGS; i++) begin
      vectors++;
      if (i >= got_acf.size() || got_acf[i] !== tx[i] || got_lag[i] !== 4'(i)) begin
        errs++; $display("FAIL nominal_word%0d: got %0d required %0d", i, (i < got_acf.size()) ? got_acf[i] : 'x, tx[i]);
      end
    end
    vectors++;
    if (n_done != 1 || n_baddone != 0) begin
      errs++; $display("FAIL nominal_done: got done=%0d misplaced=%0d required 1/0", n_done, n_baddone);
    end
    vectors++;
    if (first_v != LAGS + 2) begin
      errs++; $display("FAIL nominal_latency: got first valid cycle %0d required %0d", first_v, LAGS + 2);
    end
    vectors++;
    if (err_codes.size() != 0) begin
      errs++; $display("FAIL nominal_noerr: got %0d errors required 0", err_codes.size());
    end
  endtask

  task automatic test_short();
    load_tx(7);
    clear(); run(0, 0, 20);
    vectors++;
    if (err_codes.size() != 1 || err_codes[0] !== 2'b01 || err_cyc != 7) begin
      errs++; $display("FAIL short_err: got n=%0d cyc=%0d required one 01 at cycle 7", err_codes.size(), err_cyc);
    end
    vectors++;
    if (n_valid != 0) begin
      errs++; $display("FAIL short_novalid: got %0d valid cycles required 0", n_valid);
    end
    load_tx(LAGS + 1);
    clear(); run(0, 0, 40);
    vectors++;
    if (got_acf.size() != LAGS + 1) begin
      errs++; $display("FAIL short_recover_count: got %0d required 13", got_acf.size());
    end
    for (int i = 0; i <= LAGS; i++) begin
      vectors++;
      if (i >= got_acf.size() || got_acf[i] !== tx[i] || got_lag[i] !== 4'(i)) begin
        errs++; $display("FAIL short_recover_word%0d: got %0d required %0d", i, (i < got_acf.size()) ? got_acf[i] : 'x, tx[i]);
      end
    end
  endtask

  task automatic test_long();
    load_tx(LAGS + 2);
    clear(); run(0, 0, 30);
    vectors++;
    if (err_codes.size() != 1 || err_codes[0] !== 2'b10 || err_cyc != LAGS + 1) begin
      errs++; $display("FAIL long_err: got n=%0d cyc=%0d required one 10 at cycle 13", err_codes.size(), err_cyc);
    end
    vectors++;
    if (n_valid != 0 || n_done != 0) begin
      errs++; $display("FAIL long_noreplay: got valid=%0d done=%0d required 0/0", n_valid, n_done);
    end
    load_tx(LAGS + 1);
    clear(); run(0, 0, 40);
    vectors++;
    if (got_acf.size() != LAGS + 1 || got_acf[0] !== tx[0] || got_acf[LAGS] !== tx[LAGS] || err_codes.size() != 0) begin
      errs++; $display("FAIL long_recover: got %0d words %0d errors required 13/0", got_acf.size(), err_codes.size());
    end
  endtask

  task automatic test_stall();
    load_tx(LAGS + 1);
    clear(); run(1, 1, 100);
    vectors++;
    if (got_acf.size() != LAGS + 1 || n_unstable != 0) begin
      errs++; $display("FAIL stall_count: got words=%0d unstable=%0d required 13/0", got_acf.size(), n_unstable);
    end
    for (int i = 0; i <= LAGS; i++) begin
      vectors++;
      if (i >= got_acf.size() || got_acf[i] !== tx[i] || got_lag[i] !== 4'(i)) begin
        errs++; $display("FAIL stall_word%0d: got %0d required %0d", i, (i < got_acf.size()) ? got_acf[i] : 'x, tx[i]);
      end
    end
    vectors++;
    if (n_done != 1 || n_baddone != 0 || err_codes.size() != 0) begin
      errs++; $display("FAIL stall_done: got done=%0d misplaced=%0d errors=%0d required 1/0/0", n_done, n_baddone, err_codes.size());
    end
  endtask

  task automatic test_overrun();
    logic v;
    load_tx(LAGS + 1);
    clear();
    for (int c = 0; c < 50; c++) begin
      v = (c <= LAGS) || (c >= 19 && c < 32);
      cyc(1'b1, v, (c <= LAGS) ? tx[c] : rnd_word(), !(c >= 19 && c < 23));
    end
    vectors++;
    if (err_codes.size() != 1 || err_codes[0] !== 2'b11 || err_cyc != 19) begin
      errs++; $display("FAIL overrun_err: got n=%0d cyc=%0d required one 11 at cycle 19", err_codes.size(), err_cyc);
    end
    vectors++;
    if (got_acf.size() != LAGS + 1 || n_unstable != 0 || n_done != 1 || n_baddone != 0) begin
      errs++; $display("FAIL overrun_replay: got words=%0d unstable=%0d done=%0d required 13/0/1", got_acf.size(), n_unstable, n_done);
    end
    for (int i = 0; i <= LAGS; i++) begin
      vectors++;
      if (i >= got_acf.size() || got_acf[i] !== tx[i] || got_lag[i] !== 4'(i)) begin
        errs++; $display("FAIL overrun_word%0d: got %0d required %0d", i, (i < got_acf.size()) ? got_acf[i] : 'x, tx[i]);
      end
    end
  endtask

  task automatic test_zero_lag0();
    load_tx(LAGS + 1);
    tx[0] = '0;
    clear(); run(0, 0, 40);
`ifdef ACF_SILENT_SKIP_EN
    vectors++;
    if (n_silent != 1 || n_valid != 0) begin
      errs++; $display("FAIL zero_silent: got silent=%0d valid=%0d required 1/0", n_silent, n_valid);
    end
`else
    vectors++;
    if (n_silent != 0 || got_acf.size() != LAGS + 1 || n_done != 1) begin
      errs++; $display("FAIL zero_replay: got silent=%0d words=%0d done=%0d required 0/13/1", n_silent, got_acf.size(), n_done);
    end
    for (int i = 0; i <= LAGS; i++) begin
      vectors++;
      if (i >= got_acf.size() || got_acf[i] !== tx[i]) begin
        errs++; $display("FAIL zero_word%0d: got %0d required %0d", i, (i < got_acf.size()) ? got_acf[i] : 'x, tx[i]);
      end
    end
`endif
  endtask

  task automatic test_reset_mid_replay();
    load_tx(LAGS + 1);
    clear(); run(0, 0, LAGS + 5);
    #1;
    vectors++;
    if (oValid !== 1'b1 || oLag !== 4'd3) begin
      errs++; $display("FAIL midreset_pre: got valid=%b lag=%0d required 1/3", oValid, oLag);
    end
    iReset_n = 1'b0;
    #1;
    vectors++;
    if (oValid !== 1'b0 || oLag !== 4'd0 || oACF !== '0 || oDone !== 1'b0) begin
      errs++; $display("FAIL midreset_async: got valid=%b lag=%0d acf=%0d required 0/0/0", oValid, oLag, oACF);
    end
    @(negedge iClock);
    iReset_n = 1'b1;
    load_tx(LAGS + 1);
    clear(); run(0, 0, 40);
    vectors++;
    if (got_acf.size() != LAGS + 1 || got_acf[0] !== tx[0] || got_acf[LAGS] !== tx[LAGS]) begin
      errs++; $display("FAIL midreset_recover: got %0d words required 13", got_acf.size());
    end
  endtask

  task automatic test_random();
    int len;
    for (int it = 0; it < 12; it++) begin
      len = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, LAGS + 2)) : LAGS + 1;
      load_tx(len);
      clear(); run(2, 2, 200);
      vectors++;
      if (len <= LAGS) begin
        if (err_codes.size() != 1 || err_codes[0] !== 2'b01 || n_valid != 0) begin
          errs++; $display("FAIL random%0d_short: len=%0d got errors=%0d valid=%0d required one 01, no valid", it, len, err_codes.size(), n_valid);
        end
      end else if (len == LAGS + 2) begin
        if (err_codes.size() != 1 || err_codes[0] !== 2'b10 || n_valid != 0) begin
          errs++; $display("FAIL random%0d_long: got errors=%0d valid=%0d required one 10, no valid", it, err_codes.size(), n_valid);
        end
      end else begin
        if (got_acf != tx || n_done != 1 || n_baddone != 0 || n_unstable != 0 || err_codes.size() != 0) begin
          errs++; $display("FAIL random%0d_replay: got words=%0d done=%0d unstable=%0d errors=%0d required exact 13-word replay", it, got_acf.size(), n_done, n_unstable, err_codes.size());
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_short();
    test_long();
    test_stall();
    test_overrun();
    test_zero_lag0();
    test_reset_mid_replay();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
